// File: rtl/exec_sequencer.sv
// Instruction-driven strobe sequencer for exec_unit: drives ld/write/en_alu/en_mem
// in timed drive/gap phases and returns READ/ALU results over a valid/ready port.
module exec_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        ld,
    output logic        write,
    output logic        en_alu,
    output logic        en_mem,
    output logic [2:0]  addr,
    output logic [7:0]  indata,
    output logic [2:0]  f_select,
    input  logic [7:0]  outdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [7:0]  op_count,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for an instruction (ready only while no result is pending)
    // DRIVE | strobes asserted for HOLD_CYCLES cycles
    // GAP   | strobes low for GAP_CYCLES cycles
    // WAIT  | result still pending, holding until res_ready
    typedef enum logic [1:0] {IDLE, DRIVE, GAP, WAIT} state_t;

    localparam logic [1:0]  OP_LOAD   = 2'b00;
    localparam logic [1:0]  OP_ALU    = 2'b01;
    localparam logic [1:0]  OP_READ   = 2'b10;
    localparam logic [1:0]  OP_NOP    = 2'b11;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        res_op;
    logic        accept;
    logic [1:0]  op;

    assign op          = instr[15:14];
    assign instr_ready = (state == IDLE) && !res_valid;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res_op    <= 1'b0;
            ld        <= 1'b0;
            write     <= 1'b0;
            en_alu    <= 1'b0;
            en_mem    <= 1'b0;
            addr      <= '0;
            indata    <= '0;
            f_select  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            op_count  <= '0;
            busy      <= 1'b0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_count <= op_count + 8'd1;
                        busy     <= 1'b1;
                        if (op == OP_NOP) begin
                            state <= GAP;
                            cnt   <= GAP_LAST;
                        end else begin
                            state  <= DRIVE;
                            cnt    <= HOLD_LAST;
                            addr   <= instr[13:11];
                            res_op <= (op == OP_ALU) || (op == OP_READ);
                            ld     <= (op == OP_LOAD);
                            write  <= (op == OP_LOAD);
                            en_mem <= (op == OP_LOAD) || (op == OP_READ);
                            en_alu <= (op == OP_ALU);
                            if (op == OP_LOAD)
                                indata <= instr[7:0];
                            if (op == OP_ALU)
                                f_select <= instr[10:8];
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        ld     <= 1'b0;
                        write  <= 1'b0;
                        en_alu <= 1'b0;
                        en_mem <= 1'b0;
                        state  <= GAP;
                        cnt    <= GAP_LAST;
                        if (res_op) begin
                            res_valid <= 1'b1;
                            res_data  <= outdata;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        // A handshake on this same edge counts as consumed.
                        if (res_valid && !res_ready) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                WAIT: begin
                    if (res_valid && res_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
